mem_wb_stage: RTL

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage_if.sv | 38 +++
 rtl/mem_wb_stage.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mem_wb_stage_if.sv
// MEM-stage request and WB-stage result bundle for mem_wb_stage.
interface mem_wb_stage_if;
   // MEM-stage fields from the EX/MEM register
   logic [31:0] alu_result_m;
   logic [31:0] write_data_m;
   logic [4:0]  rd_m;
   logic [31:0] pc_plus4_m;
   logic [31:0] ext_imm_m;
   logic        reg_write_m;
   logic        mem_write_m;
   logic        lui_m;
   logic [1:0]  result_src_m;
   logic [2:0]  funct3_m;
   // WB-stage fields
   logic [4:0]  rd_w;
   logic        reg_write_w;
   logic [31:0] result_w;
   logic [31:0] alu_result_w;
   logic [31:0] read_data_w;
   logic [31:0] pc_plus4_w;
   logic [31:0] ext_imm_w;

   // Upstream pipeline drives MEM fields and observes WB fields
   modport master (
      output alu_result_m, write_data_m, rd_m, pc_plus4_m, ext_imm_m,
             reg_write_m, mem_write_m, lui_m, result_src_m, funct3_m,
      input  rd_w, reg_write_w, result_w, alu_result_w, read_data_w,
             pc_plus4_w, ext_imm_w
   );

   // The stage itself
   modport slave (
      input  alu_result_m, write_data_m, rd_m, pc_plus4_m, ext_imm_m,
             reg_write_m, mem_write_m, lui_m, result_src_m, funct3_m,
      output rd_w, reg_write_w, result_w, alu_result_w, read_data_w,
             pc_plus4_w, ext_imm_w
   );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage (4 KiB data memory, byte/half/word access) plus MEM/WB register
// and writeback result mux.
module mem_wb_stage (
   input  logic           clk,
   input  logic           rst,
   mem_wb_stage_if.slave  bus
);
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   logic [31:0] r_mem [0:1023];

   logic [9:0]  w_idx;
   logic [1:0]  w_lane;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_word;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;

   logic [4:0]  r_rd;
   logic        r_reg_write;
   logic [1:0]  r_result_src;
   logic        r_lui;
   logic [31:0] r_alu_result;
   logic [31:0] r_read_data;
   logic [31:0] r_pc_plus4;
   logic [31:0] r_ext_imm;

   assign w_idx  = bus.alu_result_m[11:2];
   assign w_lane = bus.alu_result_m[1:0];
   assign w_word = r_mem[w_idx];

   // Store lane enables; data is replicated so every enabled lane sees its bytes
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = bus.write_data_m;
      case (bus.funct3_m)
         F3_B: begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{bus.write_data_m[7:0]}};
         end
         F3_H: begin
            w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{bus.write_data_m[15:0]}};
         end
         default: ;
      endcase
   end

   // Byte-masked memory write; not reset, so stores during rst still land
   always_ff @(posedge clk) begin
      if (bus.mem_write_m) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
         end
      end
   end

   // Load extraction from the combinational read word (old data on same-cycle store)
   always_comb begin
      w_byte = w_word[w_lane*8 +: 8];
      w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];
      case (bus.funct3_m)
         F3_B:    w_load = {{24{w_byte[7]}}, w_byte};
         F3_H:    w_load = {{16{w_half[15]}}, w_half};
         F3_BU:   w_load = {24'h0, w_byte};
         F3_HU:   w_load = {16'h0, w_half};
         default: w_load = w_word;
      endcase
   end

   // MEM/WB pipeline register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd         <= '0;
         r_reg_write  <= 1'b0;
         r_result_src <= '0;
         r_lui        <= 1'b0;
         r_alu_result <= '0;
         r_read_data  <= '0;
         r_pc_plus4   <= '0;
         r_ext_imm    <= '0;
      end else begin
         r_rd         <= bus.rd_m;
         r_reg_write  <= bus.reg_write_m;
         r_result_src <= bus.result_src_m;
         r_lui        <= bus.lui_m;
         r_alu_result <= bus.alu_result_m;
         r_read_data  <= w_load;
         r_pc_plus4   <= bus.pc_plus4_m;
         r_ext_imm    <= bus.ext_imm_m;
      end
   end

   // Writeback select; LUI overrides result_src, 11 is reserved and yields 0
   always_comb begin
      if (r_lui) begin
         bus.result_w = r_ext_imm;
      end else begin
         case (r_result_src)
            2'b00:   bus.result_w = r_alu_result;
            2'b01:   bus.result_w = r_read_data;
            2'b10:   bus.result_w = r_pc_plus4;
            default: bus.result_w = 32'h0;
         endcase
      end
   end

   // x0 is never written
   assign bus.reg_write_w  = r_reg_write & (r_rd != 5'd0);
   assign bus.rd_w         = r_rd;
   assign bus.alu_result_w = r_alu_result;
   assign bus.read_data_w  = r_read_data;
   assign bus.pc_plus4_w   = r_pc_plus4;
   assign bus.ext_imm_w    = r_ext_imm;
endmodule
